// File: rtl/img_pkg.sv
// img_pkg: frame geometry, capture FSM states and RGB565 colour-bar constants
// shared by the OV7670 frame writer and its optional pattern generator.
package img_pkg;
    localparam int QVGA_W = 320;
    localparam int QVGA_H = 240;
    localparam int ADDR_W = 17;

    typedef enum logic [1:0] {SYNC, WAIT_START, ACTIVE} state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // element 0 is the leftmost bar
    localparam logic [7:0][15:0] BAR_COLORS = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                               BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};
endpackage

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: maps a pixel column to one of eight 40-pixel-wide RGB565 colour bars.
module test_pattern_gen
    import img_pkg::*;
#(
    parameter int X_W = 9
) (
    input  logic [X_W-1:0] i_x,
    output logic [15:0]    o_rgb
);
    assign o_rgb = BAR_COLORS[3'(i_x / X_W'(40))];
endmodule

// File: rtl/ov7670_img_writer.sv
// ov7670_img_writer: assembles OV7670 RGB565 byte pairs into frame-buffer writes.
// Define TEST_PATTERN_EN to replace camera colour with eight vertical colour bars.
module ov7670_img_writer
    import img_pkg::*;
#(
    parameter int IMG_W = QVGA_W,
    parameter int IMG_H = QVGA_H
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done
);
    localparam int X_W = $clog2(IMG_W + 1);
    localparam int Y_W = $clog2(IMG_H + 1);

    state_t            r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_phase;
    logic              r_href_d;
    logic [7:0]        r_hi;
    logic [15:0]       w_pix;
    logic [ADDR_W-1:0] w_addr;

`ifdef TEST_PATTERN_EN
    test_pattern_gen #(.X_W(X_W)) u_pattern (.i_x(r_x), .o_rgb(w_pix));
`else
    assign w_pix = {r_hi, data};
`endif

    assign w_addr = ADDR_W'(r_y) * ADDR_W'(IMG_W) + ADDR_W'(r_x);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= SYNC;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_phase    <= 1'b0;
            r_href_d   <= 1'b0;
            r_hi       <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            r_href_d   <= href;
            case (r_state)
                SYNC: if (vsync) r_state <= WAIT_START;
                WAIT_START: if (!vsync) begin
                    r_state <= ACTIVE;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_phase <= 1'b0;
                end
                ACTIVE: begin
                    // vsync takes priority over any line data still arriving
                    if (vsync) begin
                        frame_done <= 1'b1;
                        r_state    <= WAIT_START;
                    end else if (href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) r_hi <= data;
                        else if (r_x < X_W'(IMG_W)) begin
                            r_x <= r_x + X_W'(1);
                            if (r_y < Y_W'(IMG_H)) begin
                                we    <= 1'b1;
                                wAddr <= w_addr;
                                wData <= w_pix;
                            end
                        end
                    end else if (r_href_d) begin
                        r_x     <= '0;
                        r_phase <= 1'b0;
                        if (r_y < Y_W'(IMG_H)) r_y <= r_y + Y_W'(1);
                    end
                end
                default: r_state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_img_writer.sv
// tb_ov7670_img_writer: randomized self-checking bench; expected writes come from a
// line/pixel model of the capture rules, matched in order against the DUT write stream.
module tb_ov7670_img_writer;
    localparam int W = 320;
    localparam int H = 240;

    logic        clk = 1'b0;
    logic        reset_n, vsync, href;
    logic [7:0]  data;
    logic        we, frame_done;
    logic [16:0] wAddr;
    logic [15:0] wData;

    typedef struct { int addr; int pix; longint cyc; } wr_t;
    wr_t    exp_q[$];
    longint cyc = 0;
    int     checks = 0, failures = 0;
    int     fd_cnt = 0, fd_exp = 0, wr_cnt = 0, wr_mark = 0, last_addr = -1;
    int     y_m = 0, nl = 0, n = 0;
    bit     cap = 0, armed = 0;

    ov7670_img_writer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .href(href), .data(data),
        .we(we), .wAddr(wAddr), .wData(wData), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_pix(input int x, input int hi, input int lo);
`ifdef TEST_PATTERN_EN
        case (x / 40)
            0: return 'hFFFF;
            1: return 'hFFE0;
            2: return 'h07FF;
            3: return 'h07E0;
            4: return 'hF81F;
            5: return 'hF800;
            6: return 'h001F;
            default: return 'h0000;
        endcase
`else
        return (hi << 8) | lo;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vs(input bit v);
        tick();
        vsync = v;
        href  = 1'b0;
        if (v) begin
            if (cap) fd_exp++;
            cap   = 0;
            armed = 1;
        end else if (armed) begin
            cap   = 1;
            armed = 0;
            y_m   = 0;
        end
        repeat (v ? 3 : 0) tick();
    endtask

    // kind 1: vsync rises mid-line at abort_at; kind 2: reset asserted mid-line
    task automatic line(input int len, input int pat, input int abort_at, input int kind);
        int hi = 0;
        int b;
        for (int i = 0; i < len; i++) begin
            b = pat >= 0 ? ((i % 2 == 1) ? (pat & 'hFF) : ((pat >> 8) & 'hFF)) : int'($urandom_range(0, 255));
            tick();
            data = 8'(b);
            if (i == abort_at) begin
                href = 1'b1;
                if (kind == 1) begin
                    vsync = 1'b1;
                    if (cap) fd_exp++;
                    cap   = 0;
                    armed = 1;
                    repeat (3) tick();
                    href = 1'b0;
                    repeat (3) tick();
                end else begin
                    reset_n = 1'b0;
                    cap     = 0;
                    armed   = 0;
                    repeat (2) tick();
                    reset_n = 1'b1;
                    href    = 1'b0;
                    tick();
                end
                return;
            end
            href = 1'b1;
            if (i % 2 == 0) hi = b;
            else if (cap && i / 2 < W && y_m < H)
                exp_q.push_back('{y_m * W + i / 2, exp_pix(i / 2, hi, b), cyc + 1});
        end
        tick();
        href = 1'b0;
        if (cap) y_m++;
        repeat ($urandom_range(1, 3)) tick();
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (frame_done) fd_cnt++;
        if (we) begin
            wr_cnt++;
            last_addr = int'(wAddr);
            if (exp_q.size() == 0) check("unexpected_we", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("wAddr", wAddr, e.addr);
                check("wData", wData, e.pix);
                check("we_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; vsync = 1'b0; href = 1'b0; data = '0;
        repeat (3) tick();
        check("rst_we", we, 0);
        check("rst_wAddr", wAddr, 0);
        check("rst_wData", wData, 0);
        check("rst_frame_done", frame_done, 0);
        reset_n = 1'b1;

        line(640, -1, -1, 0);
        line(200, -1, -1, 0);
        check("midframe_writes", wr_cnt, 0);

        set_vs(1);
        set_vs(0);
        line(640, 'h1234, -1, 0);
        check("line0_writes", wr_cnt, 320);
        check("line0_last", last_addr, 319);
        line(700, -1, -1, 0);
        check("long_line_writes", wr_cnt, 640);
        check("long_line_last", last_addr, 639);
        line(5, -1, -1, 0);
        check("odd_line_writes", wr_cnt, 642);
        check("odd_line_last", last_addr, 641);
        line(11, -1, -1, 0);
        check("after_odd_writes", wr_cnt, 647);
        check("after_odd_last", last_addr, 964);
        set_vs(1);
        check("frame1_done", fd_cnt, 1);
        check("frame1_pending", exp_q.size(), 0);

        set_vs(0);
        for (int y = 0; y < H - 1; y++) line($urandom_range(1, 8), -1, -1, 0);
        line(640, -1, -1, 0);
        wr_mark = wr_cnt;
        for (int y = 0; y < 10; y++) line(40, -1, -1, 0);
        check("overflow_line_writes", wr_cnt, wr_mark);
        check("frame2_last_addr", last_addr, W * H - 1);
        set_vs(1);
        check("frame2_done", fd_cnt, 2);
        check("frame2_pending", exp_q.size(), 0);

        for (int f = 0; f < 4; f++) begin
            nl = $urandom_range(2, 5);
            set_vs(0);
            for (int l = 0; l < nl; l++) begin
                n = $urandom_range(1, 700);
                if (l == nl - 1 && $urandom_range(0, 1) == 1) line(n, -1, $urandom_range(0, n - 1), 1);
                else line(n, -1, -1, 0);
            end
            set_vs(1);
        end
        check("rand_frames_done", fd_cnt, fd_exp);
        check("rand_frames_pending", exp_q.size(), 0);

        set_vs(0);
        line(300, -1, 150, 2);
        wr_mark = wr_cnt;
        line(200, -1, -1, 0);
        check("post_reset_writes", wr_cnt, wr_mark);
        set_vs(1);
        set_vs(0);
        line(40, 'hBEEF, -1, 0);
        check("resume_last_addr", last_addr, 19);
        set_vs(1);
        check("final_done", fd_cnt, fd_exp);
        check("final_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ov7670_img_writer.md
OV7670_IMG_WRITER -- requirements
Module: ov7670_img_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per stored line.
REQ-002 SHALL have parameter IMG_H, default 240, stored lines per frame.
REQ-003 SHALL have port clk  input  1  camera pixel clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port vsync  input  1  camera frame sync, high between frames.
REQ-006 SHALL have port href  input  1  camera line valid, high while line bytes present.
REQ-007 SHALL have port data  input  8  camera byte, RGB565 high byte first.
REQ-008 SHALL have port we  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-009 SHALL have port wAddr  output  17  frame-buffer word address, y*IMG_W + x.
REQ-010 SHALL have port wData  output  16  RGB565 pixel, r[15:11] g[10:5] b[4:0].
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of a captured frame.

Function
REQ-012 SHALL implement states SYNC, WAIT_START, ACTIVE; reset enters SYNC.
REQ-013 SYNC: on vsync=1 -> WAIT_START; partial frame after reset never written.
REQ-014 WAIT_START: on vsync=0 -> ACTIVE with x=0, y=0, byte phase=0.
REQ-015 ACTIVE: each href=1 cycle toggles byte phase; phase 0 latches data as high byte, phase 1 completes pixel {hi, data}.
REQ-016 On pixel completion with x<IMG_W and y<IMG_H: next cycle we=1, wAddr=y*IMG_W+x, wData=pixel (latency 1 cycle from second byte); x increments.
REQ-017 Pixels with x>=IMG_W or lines with y>=IMG_H SHALL be dropped (we=0); x saturates at IMG_W, y at IMG_H.
REQ-018 href falling edge (href_d=1, href=0): x=0, byte phase=0, y increments; odd trailing byte discarded.
REQ-019 vsync rising in ACTIVE: frame_done=1 for one cycle, -> WAIT_START; an in-progress line is abandoned, no further writes.
REQ-020 vsync=1 while href=1 SHALL be treated as vsync (REQ-019 wins).
REQ-021 wAddr SHALL be computed in 17 bits; max value IMG_W*IMG_H-1 = 76799 at defaults.
REQ-022 we, wAddr, wData, frame_done SHALL be registered outputs.

Reset
REQ-023 With reset_n=0 at a clk edge: state=SYNC, we=0, wAddr=0, wData=0, frame_done=0, x=0, y=0, byte phase=0, href_d=0.
REQ-024 Reset mid-line SHALL abort the frame; capture resumes only after a full vsync high->low sequence.

Configuration
REQ-025 Macro TEST_PATTERN_EN: when defined, wData on each write SHALL be colour bar BAR[x/40] (8 bars, white, yellow, cyan, green, magenta, red, blue, black), data input ignored for colour; timing, addressing, dropping unchanged.
REQ-026 Without TEST_PATTERN_EN, wData SHALL be the assembled camera pixel and no pattern logic SHALL exist.

Structure
REQ-027 Package img_pkg SHALL hold QVGA_W=320, QVGA_H=240, ADDR_W=17, state enum type, and the 8-entry RGB565 bar colour constants.
REQ-028 Sub-module test_pattern_gen (x in, RGB565 out) SHALL be instantiated only under TEST_PATTERN_EN; no other sub-modules.

Verification
REQ-029 Reset then vsync 1->0, one href line of 640 bytes 0x12,0x34 repeating -> 320 writes, wAddr 0..319, wData=0x1234, we 1 cycle after each second byte.
REQ-030 Line of 700 bytes -> exactly 320 writes; next line starts at wAddr 320.
REQ-031 Full frame of 250 lines x 640 bytes then vsync rise -> last write wAddr 76799, no writes for lines 240..249, frame_done one pulse.
REQ-032 Stream starting mid-frame after reset (vsync=0, href active) -> no writes until vsync 1->0 seen.
REQ-033 Line of 5 bytes -> 2 writes, 5th byte discarded; next line x restarts at 0.
REQ-034 TEST_PATTERN_EN defined, one 640-byte line -> wData 0xFFFF for x 0..39, 0xFFE0 for 40..79, 0x0000 for 280..319.
